// File: rtl/cv32e40s_pkg.sv
// Shared types and checksum-width helpers for the OBI master adapter.
package cv32e40s_pkg;

  typedef enum logic {
    TRANSPARENT = 1'b0,
    REGISTERED  = 1'b1
  } obi_state_e;

  // One even parity per address byte, {be,we} and prot odd parities, one per wdata byte.
  function automatic int achk_width(input int addr_width, input int data_width);
    return addr_width / 8 + data_width / 8 + 2;
  endfunction

  // One even parity per rdata byte followed by the err bit.
  function automatic int rchk_width(input int data_width);
    return data_width / 8 + 1;
  endfunction

endpackage

// File: rtl/cv32e40s_obi_resp_tracker.sv
// In-order tracker for granted-but-unanswered OBI transactions.
module cv32e40s_obi_resp_tracker #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_idx, rd_idx;
  logic             wr_wrap, rd_wrap;
  logic             full, do_push, do_pop;

  assign empty   = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
  assign full    = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
  // A pop frees the slot the simultaneous push lands in.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_wrap <= 1'b0;
      rd_idx  <= '0;
      rd_wrap <= 1'b0;
    end else begin
      if (do_push) begin
        wr_idx  <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
        wr_wrap <= (wr_idx == LAST) ? ~wr_wrap : wr_wrap;
      end
      if (do_pop) begin
        rd_idx  <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
        rd_wrap <= (rd_idx == LAST) ? ~rd_wrap : rd_wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/cv32e40s_obi_master_adapter.sv
// OBI master adapter: holds stalled requests stable, tracks outstanding
// transactions and checks handshake parity and response checksums.
module cv32e40s_obi_master_adapter
  import cv32e40s_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_MODE       = 0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        trans_valid_i,
  output logic                                        trans_ready_o,
  input  logic [ADDR_WIDTH-1:0]                       trans_addr_i,
  input  logic                                        trans_we_i,
  input  logic [DATA_WIDTH/8-1:0]                     trans_be_i,
  input  logic [DATA_WIDTH-1:0]                       trans_wdata_i,
  input  logic [2:0]                                  trans_prot_i,
  input  logic                                        trans_integrity_i,
  output logic                                        obi_req_o,
  output logic                                        obi_reqpar_o,
  input  logic                                        obi_gnt_i,
  input  logic                                        obi_gntpar_i,
  output logic [ADDR_WIDTH-1:0]                       obi_addr_o,
  output logic                                        obi_we_o,
  output logic [DATA_WIDTH/8-1:0]                     obi_be_o,
  output logic [DATA_WIDTH-1:0]                       obi_wdata_o,
  output logic [2:0]                                  obi_prot_o,
  output logic [achk_width(ADDR_WIDTH,DATA_WIDTH)-1:0] obi_achk_o,
  input  logic                                        obi_rvalid_i,
  input  logic                                        obi_rvalidpar_i,
  input  logic [DATA_WIDTH-1:0]                       obi_rdata_i,
  input  logic                                        obi_err_i,
  input  logic [rchk_width(DATA_WIDTH)-1:0]           obi_rchk_i,
  output logic                                        resp_valid_o,
  output logic [DATA_WIDTH-1:0]                       resp_rdata_o,
  output logic                                        resp_err_o,
  output logic                                        resp_integrity_o,
  output logic                                        resp_integrity_err_o,
  output logic                                        integrity_err_o,
  output logic                                        integrity_err_sticky_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]        outstanding_cnt_o
);

  localparam int AB = ADDR_WIDTH / 8;
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BW-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [2:0]            prot;
    logic                  integrity;
  } apl_t;

  obi_state_e state_q, state_d;
  apl_t       cur, pl, pl_q;
  logic [CW-1:0] cnt_q;
  logic       cnt_ok, grant, pop, sticky_q;
  logic       gntpar_err, rvalidpar_err, rchk_err, protocol_err;
  logic [1:0] head;
  logic       empty, head_int, head_gpe;
  logic [BW:0] rchk_exp;

  // Instruction-side adapters never write, so the write fields are tied off.
  always_comb begin
    cur.addr      = trans_addr_i;
    cur.we        = (DATA_MODE != 0) ? trans_we_i    : 1'b0;
    cur.be        = (DATA_MODE != 0) ? trans_be_i    : '1;
    cur.wdata     = (DATA_MODE != 0) ? trans_wdata_i : '0;
    cur.prot      = trans_prot_i;
    cur.integrity = trans_integrity_i;
  end

  assign cnt_ok = cnt_q < CNT_MAX;

  always_comb begin
    state_d       = state_q;
    pl            = cur;
    obi_req_o     = trans_valid_i;
    trans_ready_o = 1'b1;
    if (rst_n) begin
      case (state_q)
        TRANSPARENT: begin
          obi_req_o     = trans_valid_i && cnt_ok;
          trans_ready_o = cnt_ok;
          if (obi_req_o && !obi_gnt_i) state_d = REGISTERED;
        end
        REGISTERED: begin
          obi_req_o     = 1'b1;
          trans_ready_o = 1'b0;
          pl            = pl_q;
          if (obi_gnt_i) state_d = TRANSPARENT;
        end
        default: state_d = TRANSPARENT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TRANSPARENT;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == TRANSPARENT && state_d == REGISTERED) pl_q <= cur;
    end
  end

  assign obi_reqpar_o = !obi_req_o;
  assign obi_addr_o   = pl.addr;
  assign obi_we_o     = pl.we;
  assign obi_be_o     = pl.be;
  assign obi_wdata_o  = pl.wdata;
  assign obi_prot_o   = pl.prot;

  always_comb begin
    obi_achk_o = '0;
    for (int i = 0; i < AB; i++) obi_achk_o[i] = ^pl.addr[8*i +: 8];
    obi_achk_o[AB]   = ~^{pl.be, pl.we};
    obi_achk_o[AB+1] = ~^pl.prot;
    for (int j = 0; j < BW; j++) obi_achk_o[AB+2+j] = ^pl.wdata[8*j +: 8];
  end

  assign grant         = obi_req_o && obi_gnt_i;
  assign gntpar_err    = (obi_gnt_i == obi_gntpar_i);
  assign rvalidpar_err = (obi_rvalid_i == obi_rvalidpar_i);
  // A response with nothing outstanding is a protocol violation, not a pop.
  assign protocol_err  = obi_rvalid_i && (cnt_q == '0);
  assign pop           = obi_rvalid_i && (cnt_q != '0);

  cv32e40s_obi_resp_tracker #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (2)
  ) u_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .wdata ({pl.integrity, gntpar_err}),
    .pop   (pop),
    .head  (head),
    .empty (empty)
  );

  assign head_int = !empty && head[1];
  assign head_gpe = !empty && head[0];

  always_comb begin
    rchk_exp = '0;
    for (int j = 0; j < BW; j++) rchk_exp[j] = ^obi_rdata_i[8*j +: 8];
    rchk_exp[BW] = obi_err_i;
  end

  assign rchk_err = obi_rvalid_i && head_int && (obi_rchk_i != rchk_exp);

  assign resp_valid_o         = obi_rvalid_i;
  assign resp_rdata_o         = obi_rdata_i;
  assign resp_err_o           = obi_err_i;
  assign resp_integrity_o     = head_int;
  assign resp_integrity_err_o = obi_rvalid_i &&
                                (rvalidpar_err || head_gpe || rchk_err || protocol_err);
  assign integrity_err_o      = gntpar_err || rvalidpar_err || rchk_err || protocol_err;
  assign integrity_err_sticky_o = sticky_q;
  assign outstanding_cnt_o    = rst_n ? cnt_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_q || integrity_err_o;
      if (grant && !pop && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      else if (pop && !grant)                cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule
